// File: rtl/fft_pkg.sv
// Shared constants and state types for the ADC front end and the FFT blocks.
// Sample width, transform size and FSM encodings live here.
package fft_pkg;

    localparam int N_POINTS = 16;
    localparam int LOG2N    = 4;
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {
        S_GAP,
        S_LOW,
        S_HIGH
    } spi_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_BURST,
        B_WAIT
    } burst_state_t;

endpackage

// File: rtl/adc_sample_buffer_if.sv
// Loader bus between the sample buffer and the FFT core.
// The buffer drives insert_data/addr/data_in; the FFT answers with fft_finish.
interface adc_sample_buffer_if;
    import fft_pkg::*;

    logic              insert_data;
    logic [LOG2N-1:0]  addr;
    logic [DATA_W-1:0] data_in;
    logic              fft_finish;

    modport master (
        output insert_data,
        output addr,
        output data_in,
        input  fft_finish
    );

    modport slave (
        input  insert_data,
        input  addr,
        input  data_in,
        output fft_finish
    );

endinterface

// File: rtl/adc_spi_rx.sv
// SPI master for a serial ADC: frames CS, generates SCLK, shifts MISO in
// and turns each offset-binary result into a sign-extended sample.
module adc_spi_rx
    import fft_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int ADC_BITS   = 12,
    parameter int CS_HIGH    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_cs,
    output logic [DATA_W-1:0] sample,
    output logic              sample_dv
);

    localparam int CMAX = (CS_HIGH > CLK_DIV) ? CS_HIGH : CLK_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] GAP_LAST = CW'(CS_HIGH - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    spi_state_t          state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       nbit;
    logic [ADC_BITS-1:0] shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_GAP;
            cnt       <= '0;
            nbit      <= '0;
            shift     <= '0;
            adc_sclk  <= 1'b0;
            adc_cs    <= 1'b1;
            sample    <= '0;
            sample_dv <= 1'b0;
        end else begin
            sample_dv <= 1'b0;
            unique case (state)
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        adc_cs <= 1'b0;
                        state  <= S_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        adc_sclk <= 1'b1;
                        shift    <= {shift[ADC_BITS-2:0], adc_miso};
                        state    <= S_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        adc_sclk <= 1'b0;
                        if (nbit == BIT_LAST) begin
                            // MSB flip maps offset-binary onto two's complement
                            nbit      <= '0;
                            adc_cs    <= 1'b1;
                            sample    <= {{(DATA_W-ADC_BITS){~shift[ADC_BITS-1]}},
                                          ~shift[ADC_BITS-1],
                                          shift[ADC_BITS-2:0]};
                            sample_dv <= 1'b1;
                            state     <= S_GAP;
                        end else begin
                            nbit  <= nbit + 1'b1;
                            state <= S_LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_GAP;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_buffer.sv
// Ping-pong sample buffer: collects ADC samples into two banks and bursts
// each full bank into the FFT loader, pacing bursts on fft_finish.
module adc_sample_buffer
    import fft_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int ADC_BITS   = 12,
    parameter int CS_HIGH    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adc_miso,
    output logic adc_sclk,
    output logic adc_cs,
    output logic sample_dv,
    output logic overrun,
    adc_sample_buffer_if.master ld
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);

    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] bank [2][N_POINTS];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [LOG2N-1:0]  wr_idx;
    logic [LOG2N-1:0]  rd_idx;
    burst_state_t      bstate;
    logic              wr_en;

    adc_spi_rx #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .ADC_BITS   (ADC_BITS),
        .CS_HIGH    (CS_HIGH)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_miso  (adc_miso),
        .adc_sclk  (adc_sclk),
        .adc_cs    (adc_cs),
        .sample    (sample),
        .sample_dv (sample_dv)
    );

    assign wr_en = sample_dv && !full[wr_bank];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[wr_bank][wr_idx] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full           <= '0;
            wr_bank        <= 1'b0;
            wr_idx         <= '0;
            rd_bank        <= 1'b0;
            rd_idx         <= '0;
            bstate         <= B_IDLE;
            overrun        <= 1'b0;
            ld.insert_data <= 1'b0;
            ld.addr        <= '0;
            ld.data_in     <= '0;
        end else begin
            // full is the pre-edge value, so a bank freed this cycle still drops
            if (sample_dv) begin
                if (full[wr_bank]) begin
                    overrun <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                    if (wr_idx == LAST) begin
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= ~wr_bank;
                    end
                end
            end
            unique case (bstate)
                B_IDLE: begin
                    ld.insert_data <= 1'b0;
                    ld.addr        <= '0;
                    ld.data_in     <= '0;
                    if (full[rd_bank]) begin
                        rd_idx <= '0;
                        bstate <= B_BURST;
                    end
                end
                B_BURST: begin
                    ld.insert_data <= 1'b1;
                    ld.addr        <= rd_idx;
                    ld.data_in     <= bank[rd_bank][rd_idx];
                    rd_idx         <= rd_idx + 1'b1;
                    if (rd_idx == LAST) begin
                        full[rd_bank] <= 1'b0;
                        rd_bank       <= ~rd_bank;
                        bstate        <= B_WAIT;
                    end
                end
                B_WAIT: begin
                    ld.insert_data <= 1'b0;
                    ld.addr        <= '0;
                    ld.data_in     <= '0;
                    if (ld.fft_finish) begin
                        bstate <= B_IDLE;
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Bench for adc_sample_buffer: ADC serial model, burst scoreboard,
// frame timing, overrun, fft_finish pacing and mid-operation reset.
module tb_adc_sample_buffer;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic adc_miso = 1'b0;
    logic adc_sclk;
    logic adc_cs;
    logic sample_dv;
    logic overrun;

    adc_sample_buffer_if bus();

    adc_sample_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_miso  (adc_miso),
        .adc_sclk  (adc_sclk),
        .adc_cs    (adc_cs),
        .sample_dv (sample_dv),
        .overrun   (overrun),
        .ld        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ndv = 0;
    int last_dv = 0;
    int dv_gap = 0;
    int run = 0;
    int first_lat = 0;
    int base = 0;
    beat_t exq[$];
    beat_t cur;
    logic [11:0] codes[$];

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endfunction

    function automatic void fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want DUT event", name);
    endfunction

    // ADC model: result right-justified in a 16-bit frame, MSB first
    logic [15:0] word = '0;
    logic        cs_seen = 1'b0;
    always @(negedge adc_cs or posedge adc_cs or negedge adc_sclk) begin
        if (adc_cs !== 1'b0) begin
            cs_seen = 1'b0;
        end else if (!cs_seen) begin
            cs_seen = 1'b1;
            if (codes.size() > 0) word = {4'h0, codes.pop_front()};
            else word = 16'h0800;
            adc_miso = word[15];
        end else begin
            word = {word[14:0], 1'b0};
            adc_miso = word[15];
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            run = 0;
        end else if (bus.insert_data) begin
            if (run == 0) first_lat = cyc - last_dv;
            run++;
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat_unexpected: got addr %0h data %0h want none",
                         bus.addr, bus.data_in);
            end else begin
                cur = exq.pop_front();
                chk("beat_addr", 32'(bus.addr), 32'(cur.a));
                chk("beat_data", 32'(bus.data_in), 32'(cur.d));
            end
        end else if (run != 0) begin
            chk("burst_len", run, 16);
            run = 0;
        end
        if (sample_dv) begin
            dv_gap = cyc - last_dv;
            last_dv = cyc;
            ndv++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cs"}, 32'(adc_cs), 1);
        chk({tag, "_sclk"}, 32'(adc_sclk), 0);
        chk({tag, "_ins"}, 32'(bus.insert_data), 0);
        chk({tag, "_addr"}, 32'(bus.addr), 0);
        chk({tag, "_data"}, 32'(bus.data_in), 0);
        chk({tag, "_dv"}, 32'(sample_dv), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    task automatic wait_ins(input logic lvl, input int lim, input string name);
        int n = 0;
        while (bus.insert_data !== lvl && n < lim) begin
            tick();
            n++;
        end
        if (bus.insert_data !== lvl) fail_to(name);
    endtask

    task automatic wait_addr(input logic [3:0] a, input int lim, input string name);
        int n = 0;
        while (!(bus.insert_data === 1'b1 && bus.addr === a) && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) fail_to(name);
    endtask

    task automatic wait_dv(input int k, input string name, output logic saw);
        int lim;
        saw = 1'b0;
        lim = (k - (ndv - base)) * 136 + 300;
        while ((ndv - base) < k && lim > 0) begin
            if (bus.insert_data) saw = 1'b1;
            tick();
            lim--;
        end
        if ((ndv - base) < k) fail_to(name);
    endtask

    task automatic pulse_finish();
        bus.fft_finish = 1'b1;
        tick();
        bus.fft_finish = 1'b0;
    endtask

    task automatic load(input logic [11:0] code, input logic [3:0] a,
                        input logic [15:0] d);
        beat_t b;
        codes.push_back(code);
        b.a = a;
        b.d = d;
        exq.push_back(b);
    endtask

    logic [11:0] b1_code [16] = '{
        12'h800, 12'hFFF, 12'h000, 12'h7FF, 12'h801, 12'hC00, 12'h400, 12'h123,
        12'hABC, 12'h809, 12'h80A, 12'h80B, 12'h80C, 12'h80D, 12'h80E, 12'h80F};
    logic [15:0] b1_exp [16] = '{
        16'h0000, 16'h07FF, 16'hF800, 16'hFFFF, 16'h0001, 16'h0400, 16'hFC00, 16'hF923,
        16'h02BC, 16'h0009, 16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E, 16'h000F};

    initial begin
        int lowc, rises, highc, gapc;
        logic prev, saw;
        bus.fft_finish = 1'b0;
        repeat (3) tick();
        chk_reset("rst_init");

        for (int i = 0; i < 16; i++) load(b1_code[i], 4'(i), b1_exp[i]);
        for (int i = 0; i < 16; i++) load(12'h800 + 12'(i), 4'(i), 16'h0000 + 16'(i));
        for (int i = 0; i < 16; i++) load(12'h900 + 12'(i), 4'(i), 16'h0100 + 16'(i));
        for (int i = 0; i < 16; i++) load(12'hA00 + 12'(i), 4'(i), 16'h0200 + 16'(i));
        for (int i = 0; i < 16; i++) load(12'hB00 + 12'(i), 4'(i), 16'h0300 + 16'(i));
        codes.push_back(12'hC00);
        base = ndv;
        rst_n = 1'b1;

        lowc = 0;
        while (adc_cs !== 1'b0 && lowc < 50) begin
            tick();
            lowc++;
        end
        if (adc_cs !== 1'b0) fail_to("cs_fall");
        lowc = 0;
        rises = 0;
        highc = 0;
        prev = 1'b0;
        while (adc_cs === 1'b0 && lowc < 400) begin
            lowc++;
            if (adc_sclk) highc++;
            if (adc_sclk && !prev) rises++;
            prev = adc_sclk;
            tick();
        end
        chk("dv_at_cs_rise", 32'(sample_dv), 1);
        chk("sclk_low_at_end", 32'(adc_sclk), 0);
        gapc = 0;
        while (adc_cs === 1'b1 && gapc < 100) begin
            gapc++;
            tick();
        end
        chk("cs_low_cycles", lowc, 128);
        chk("sclk_rises", rises, 16);
        chk("sclk_high_cycles", highc, 64);
        chk("cs_high_cycles", gapc, 8);
        wait_dv(2, "dv2", saw);
        chk("dv_period", dv_gap, 136);

        wait_ins(1'b1, 3000, "burst1_start");
        wait_ins(1'b0, 100, "burst1_end");
        chk("burst1_latency", first_lat, 3);
        chk("burst1_ovr", 32'(overrun), 0);
        repeat (20) tick();
        pulse_finish();
        wait_ins(1'b1, 3000, "burst2_start");
        wait_ins(1'b0, 100, "burst2_end");
        chk("burst2_latency", first_lat, 3);
        chk("burst2_ovr", 32'(overrun), 0);
        repeat (20) tick();
        pulse_finish();

        // finish during a burst must not release the wait state
        wait_addr(4'd8, 3000, "burst3_mid");
        pulse_finish();
        wait_ins(1'b0, 100, "burst3_end");
        wait_dv(80, "dv80", saw);
        repeat (2) tick();
        chk("ovr_before_drop", 32'(overrun), 0);
        chk("no_burst_held_a", 32'(saw), 0);
        wait_dv(81, "dv81", saw);
        repeat (2) tick();
        chk("ovr_after_drop", 32'(overrun), 1);
        chk("no_burst_held_b", 32'(saw | bus.insert_data), 0);
        pulse_finish();
        wait_ins(1'b1, 50, "burst4_start");
        wait_ins(1'b0, 100, "burst4_end");
        repeat (20) tick();
        pulse_finish();
        wait_ins(1'b1, 50, "burst5_start");
        wait_ins(1'b0, 100, "burst5_end");
        chk("exq_empty_a", exq.size(), 0);

        lowc = 0;
        while (adc_cs !== 1'b0 && lowc < 300) begin
            tick();
            lowc++;
        end
        repeat (30) tick();
        rst_n = 1'b0;
        tick();
        chk_reset("rst_frame");
        rst_n = 1'b1;
        codes.delete();
        for (int i = 0; i < 16; i++) load(12'hD00 + 12'(i), 4'(i), 16'h0500 + 16'(i));

        wait_addr(4'd5, 3000, "burst6_mid");
        rst_n = 1'b0;
        tick();
        chk_reset("rst_burst");
        rst_n = 1'b1;
        exq.delete();
        codes.delete();
        for (int i = 0; i < 16; i++) load(12'hE00 + 12'(i), 4'(i), 16'h0600 + 16'(i));
        wait_ins(1'b1, 3000, "burst7_start");
        wait_ins(1'b0, 100, "burst7_end");
        chk("burst7_latency", first_lat, 3);
        chk("exq_empty_b", exq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
